cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The module SHALL have parameter REG_ADD, default 4, giving the width of the opcode, extension and condition fields.
REQ-002 The module SHALL have parameter PSRL, default 5, giving the width of the status-flag vector.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- OP_CODE  in  REG_ADD  instruction bits 15:12.
- OP_EXT  in  REG_ADD  instruction bits 7:4.
- COND  in  REG_ADD  instruction bits 11:8, used as the branch condition.
- PSR_OUT  in  PSRL  flags {N,Z,F,L,C}, with N at bit 4 and C at bit 0.
- MEM_READY  in  1  memory handshake: high means the current access completes this cycle.
- PC_S, MEM_S  out  1 each  mux2 selects.
- WD_S, ALUA_S, ALUB_S  out  2 each  mux4 selects.
- INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, REG_WR  out  1 each  register enables.
- SE_SIGN  out  1  1 = sign-extend immediate, 0 = zero-extend.
- MEM_WE  out  1  memory write strobe.
- ALU_ADD  out  1  forces the ALU operation to ADD.
- STATE  out  4  current state encoding (debug).
- INSTR_CNT  out  16  retired-instruction count.

Function
REQ-004 Select encodings SHALL be:
- MEM_S: 0 = Rdest, 1 = PC.
- PC_S: 0 = Rsrc, 1 = ALU result.
- WD_S: 0 = IMM_EXT, 1 = Rsrc, 2 = MEM_OUT, 3 = ALU_OUT.
- ALUA_S: 0 = Rsrc, 1 = PC, 2 = IMM_EXT.
- ALUB_S: 0 = Rdest, 1 = IMM_EXT, 2 = constant one.
REQ-005 The controller SHALL be a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, ALU_WB=3, MOV_WB=4, MOVI_WB=5, LD_RD=6, LD_WB=7, ST_WR=8, BRANCH=9, JUMP=10. Any other encoding SHALL go to FETCH.
REQ-006 FETCH behaviour:
- Drives MEM_S=1, ALUA_S=1, ALUB_S=2, ALU_ADD=1, PC_S=1.
- While MEM_READY=0 it holds, with INSTR_EN=0 and PC_EN=0.
- When MEM_READY=1 it asserts INSTR_EN=1 and PC_EN=1 for that cycle, then goes to DECODE.
REQ-007 DECODE SHALL assert no enables and SHALL branch on the instruction:
- OP_CODE 0000 with OP_EXT 1101 -> MOV_WB.
- OP_CODE 0000, other OP_EXT -> EXEC.
- OP_CODE 1101 -> MOVI_WB.
- OP_CODE 0100 with OP_EXT 0000 -> LD_RD.
- OP_CODE 0100 with OP_EXT 0100 -> ST_WR.
- OP_CODE 0100 with OP_EXT 1100 -> JUMP.
- OP_CODE 1100 -> BRANCH.
- Other OP_CODE 0100 extensions and OP_CODE 1111 -> FETCH (NOP).
- All remaining opcodes are immediate ALU ops -> EXEC.
REQ-008 EXEC SHALL assert ALU_OUT_EN=1 and PSR_EN=1, then go to ALU_WB, except compare (OP_EXT 1011 with OP_CODE 0000, or OP_CODE 1011), which goes to FETCH. Operand selects:
- Register form: ALUA_S=0, ALUB_S=0.
- Immediate form: ALUA_S=2, ALUB_S=1, SE_SIGN=1.
REQ-009 ALU_WB SHALL assert REG_WR=1 with WD_S=3; MOV_WB SHALL assert REG_WR=1 with WD_S=1; MOVI_WB SHALL assert REG_WR=1 with WD_S=0 and SE_SIGN=0. Each of these states goes to FETCH.
REQ-010 LD_RD SHALL drive MEM_S=0 and hold until MEM_READY=1, then assert MEM_REG_EN=1 and go to LD_WB. LD_WB SHALL assert REG_WR=1 with WD_S=2.
REQ-011 ST_WR SHALL drive MEM_S=0 with MEM_WE=1 until and including the MEM_READY=1 cycle, then go to FETCH.
REQ-012 BRANCH SHALL drive ALUA_S=1, ALUB_S=1, SE_SIGN=1, ALU_ADD=1, PC_S=1, and SHALL assert PC_EN only if the condition holds. The branch target is therefore PC+1+disp.
REQ-013 JUMP SHALL drive PC_S=0 and SHALL assert PC_EN only if the condition holds.
REQ-014 Condition codes SHALL be:
- 0000 EQ (Z)
- 0001 NE (!Z)
- 0010 CS (C)
- 0011 CC (!C)
- 0110 GT (N)
- 0111 LE (!N)
- 1110 UC (always true)
- all other codes: never true.
REQ-015 The outputs not named for a state SHALL be 0.
REQ-016 INSTR_CNT SHALL increment by 1 on every transition into FETCH from any state other than FETCH, and SHALL wrap from 0xFFFF to 0x0000.
REQ-017 Latencies SHALL be, with zero memory wait states: ALU op 4 cycles, compare 3, MOV/MOVI 3, load 4, store 3, branch/jump 3, NOP 2. Each memory wait cycle adds 1 cycle.

Reset
REQ-018 When reset=0, state SHALL go to FETCH and INSTR_CNT to 0 asynchronously, and all enables, REG_WR and MEM_WE SHALL be forced to 0 regardless of state.
REQ-019 A reset assertion mid-access (LD_RD or ST_WR) SHALL drop MEM_WE in the same cycle. After release, fetching SHALL resume at FETCH.

Structure
REQ-020 State encodings, opcode/extension constants, condition codes and select encodings SHALL live in a shared package, cpu_defs.
REQ-021 Condition evaluation SHALL be a combinational sub-module, cond_check, with inputs COND and PSR_OUT and a single-bit taken output.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset released, MEM_READY=1, OP_CODE=0000, OP_EXT=0101 -> states 0,1,2,3,0; REG_WR=1 only in state 3; INSTR_CNT=1.
- FETCH with MEM_READY held low 3 cycles -> INSTR_EN=0 for 3 cycles, then 1 for one cycle.
- BRANCH, COND=0000, PSR_OUT=5'b01000 -> PC_EN=1; with PSR_OUT=0 -> PC_EN=0; both paths return to FETCH.
- Store with MEM_READY low 2 cycles -> MEM_WE=1 for 3 cycles; reset pulled low in the second cycle -> MEM_WE=0 immediately and STATE=0.
- Load -> MEM_REG_EN=1 in LD_RD, then REG_WR=1 with WD_S=2.
- Preload INSTR_CNT to 0xFFFF and retire one instruction -> INSTR_CNT=0x0000.

Source files
------------

// File: rtl/cpu_defs.sv
// cpu_defs: shared constants for the multi-cycle CPU controller.
//   - FSM state encodings (exposed on the STATE debug port)
//   - opcode / extension values the decoder distinguishes
//   - branch/jump condition codes and PSR flag bit positions
//   - datapath mux select encodings
package cpu_defs;

   // FSM state encodings
   localparam logic [3:0] ST_FETCH   = 4'd0;
   localparam logic [3:0] ST_DECODE  = 4'd1;
   localparam logic [3:0] ST_EXEC    = 4'd2;
   localparam logic [3:0] ST_ALU_WB  = 4'd3;
   localparam logic [3:0] ST_MOV_WB  = 4'd4;
   localparam logic [3:0] ST_MOVI_WB = 4'd5;
   localparam logic [3:0] ST_LD_RD   = 4'd6;
   localparam logic [3:0] ST_LD_WB   = 4'd7;
   localparam logic [3:0] ST_ST_WR   = 4'd8;
   localparam logic [3:0] ST_BRANCH  = 4'd9;
   localparam logic [3:0] ST_JUMP    = 4'd10;

   // Opcodes (instruction bits 15:12)
   localparam logic [3:0] OPC_RTYPE = 4'b0000;
   localparam logic [3:0] OPC_MEM   = 4'b0100;
   localparam logic [3:0] OPC_CMPI  = 4'b1011;
   localparam logic [3:0] OPC_BCOND = 4'b1100;
   localparam logic [3:0] OPC_MOVI  = 4'b1101;
   localparam logic [3:0] OPC_NOP   = 4'b1111;

   // Extensions (instruction bits 7:4)
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_CMP   = 4'b1011;
   localparam logic [3:0] EXT_JCOND = 4'b1100;
   localparam logic [3:0] EXT_MOV   = 4'b1101;

   // Condition codes (instruction bits 11:8)
   localparam logic [3:0] CC_EQ = 4'b0000;
   localparam logic [3:0] CC_NE = 4'b0001;
   localparam logic [3:0] CC_CS = 4'b0010;
   localparam logic [3:0] CC_CC = 4'b0011;
   localparam logic [3:0] CC_GT = 4'b0110;
   localparam logic [3:0] CC_LE = 4'b0111;
   localparam logic [3:0] CC_UC = 4'b1110;

   // PSR flag positions: {N,Z,F,L,C}
   localparam int PSR_N = 4;
   localparam int PSR_Z = 3;
   localparam int PSR_F = 2;
   localparam int PSR_L = 1;
   localparam int PSR_C = 0;

   // Mux select encodings
   localparam logic       MEM_S_RDEST  = 1'b0;
   localparam logic       MEM_S_PC     = 1'b1;
   localparam logic       PC_S_RSRC    = 1'b0;
   localparam logic       PC_S_ALU     = 1'b1;
   localparam logic [1:0] WD_S_IMM     = 2'd0;
   localparam logic [1:0] WD_S_RSRC    = 2'd1;
   localparam logic [1:0] WD_S_MEM     = 2'd2;
   localparam logic [1:0] WD_S_ALU     = 2'd3;
   localparam logic [1:0] ALUA_S_RSRC  = 2'd0;
   localparam logic [1:0] ALUA_S_PC    = 2'd1;
   localparam logic [1:0] ALUA_S_IMM   = 2'd2;
   localparam logic [1:0] ALUB_S_RDEST = 2'd0;
   localparam logic [1:0] ALUB_S_IMM   = 2'd1;
   localparam logic [1:0] ALUB_S_ONE   = 2'd2;

endpackage

// File: rtl/cpu_controller_if.sv
// cpu_controller_if: bundle of the controller <-> datapath/memory signals.
//   Instruction fields OP_CODE/OP_EXT/COND and the PSR_OUT flags come from
//   the datapath; MEM_READY comes from memory; all selects, enables, strobes
//   and the STATE/INSTR_CNT debug values go from the controller outward.
// Handshake: the controller holds a memory access (fetch, load or store)
//   presented every cycle until memory raises MEM_READY; the cycle in which
//   MEM_READY is high is the cycle the access completes, and the controller
//   moves on at the following clock edge. There is no separate request
//   strobe; being in an access state is the request.
interface cpu_controller_if #(
   parameter int REG_ADD = 4,
   parameter int PSRL    = 5
) ();
   logic [REG_ADD-1:0] OP_CODE;
   logic [REG_ADD-1:0] OP_EXT;
   logic [REG_ADD-1:0] COND;
   logic [PSRL-1:0]    PSR_OUT;
   logic               MEM_READY;
   logic               PC_S;
   logic               MEM_S;
   logic [1:0]         WD_S;
   logic [1:0]         ALUA_S;
   logic [1:0]         ALUB_S;
   logic               INSTR_EN;
   logic               ALU_OUT_EN;
   logic               MEM_REG_EN;
   logic               PC_EN;
   logic               PSR_EN;
   logic               REG_WR;
   logic               SE_SIGN;
   logic               MEM_WE;
   logic               ALU_ADD;
   logic [3:0]         STATE;
   logic [15:0]        INSTR_CNT;

   // Controller side
   modport master (
      input  OP_CODE, OP_EXT, COND, PSR_OUT, MEM_READY,
      output PC_S, MEM_S, WD_S, ALUA_S, ALUB_S,
      output INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, REG_WR,
      output SE_SIGN, MEM_WE, ALU_ADD, STATE, INSTR_CNT
   );

   // Datapath / memory side
   modport slave (
      output OP_CODE, OP_EXT, COND, PSR_OUT, MEM_READY,
      input  PC_S, MEM_S, WD_S, ALUA_S, ALUB_S,
      input  INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, REG_WR,
      input  SE_SIGN, MEM_WE, ALU_ADD, STATE, INSTR_CNT
   );
endinterface

// File: rtl/cond_check.sv
// cond_check: combinational branch/jump condition evaluator.
//   COND    - condition code field of the instruction
//   PSR_OUT - status flags {N,Z,F,L,C}
//   taken   - 1 when the condition holds; unknown codes are never taken
module cond_check
   import cpu_defs::*;
#(
   parameter int REG_ADD = 4,
   parameter int PSRL    = 5
) (
   input  logic [REG_ADD-1:0] COND,
   input  logic [PSRL-1:0]    PSR_OUT,
   output logic               taken
);

   // F and L do not take part in any condition this controller supports.
   logic unused_flags;
   assign unused_flags = ^{PSR_OUT[PSR_F], PSR_OUT[PSR_L]};

   always_comb begin
      taken = 1'b0;
      case (COND)
         REG_ADD'(CC_EQ): taken = PSR_OUT[PSR_Z];
         REG_ADD'(CC_NE): taken = ~PSR_OUT[PSR_Z];
         REG_ADD'(CC_CS): taken = PSR_OUT[PSR_C];
         REG_ADD'(CC_CC): taken = ~PSR_OUT[PSR_C];
         REG_ADD'(CC_GT): taken = PSR_OUT[PSR_N];
         REG_ADD'(CC_LE): taken = ~PSR_OUT[PSR_N];
         REG_ADD'(CC_UC): taken = 1'b1;
         default:         taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing a multi-cycle CPU datapath.
//   clk/reset             - rising-edge clock, async active-low reset
//   OP_CODE/OP_EXT/COND   - instruction fields from the instruction register
//   PSR_OUT               - status flags {N,Z,F,L,C}
//   MEM_READY             - memory access completes this cycle
//   PC_S, MEM_S, WD_S,
//   ALUA_S, ALUB_S        - datapath mux selects
//   *_EN, REG_WR, MEM_WE  - register enables / write strobes (0 in reset)
//   SE_SIGN, ALU_ADD      - immediate extension mode, force ALU to ADD
//   STATE                 - current FSM state (debug)
//   INSTR_CNT             - retired-instruction counter, wraps at 16 bits
module cpu_controller
   import cpu_defs::*;
#(
   parameter int REG_ADD = 4,
   parameter int PSRL    = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [REG_ADD-1:0] OP_CODE,
   input  logic [REG_ADD-1:0] OP_EXT,
   input  logic [REG_ADD-1:0] COND,
   input  logic [PSRL-1:0]    PSR_OUT,
   input  logic               MEM_READY,
   output logic               PC_S,
   output logic               MEM_S,
   output logic [1:0]         WD_S,
   output logic [1:0]         ALUA_S,
   output logic [1:0]         ALUB_S,
   output logic               INSTR_EN,
   output logic               ALU_OUT_EN,
   output logic               MEM_REG_EN,
   output logic               PC_EN,
   output logic               PSR_EN,
   output logic               REG_WR,
   output logic               SE_SIGN,
   output logic               MEM_WE,
   output logic               ALU_ADD,
   output logic [3:0]         STATE,
   output logic [15:0]        INSTR_CNT
);

   logic [3:0]  state_q, state_d;
   logic [15:0] instr_cnt_q, instr_cnt_d;
   logic        cond_taken;
   logic        is_rtype;
   logic        is_cmp;

   // Ungated enables; the reset gating below keeps them quiet while reset
   // is low even though FETCH (the reset state) would otherwise react to
   // MEM_READY.
   logic instr_en_c, alu_out_en_c, mem_reg_en_c, pc_en_c;
   logic psr_en_c, reg_wr_c, mem_we_c;

   cond_check #(
      .REG_ADD (REG_ADD),
      .PSRL    (PSRL)
   ) u_cond_check (
      .COND    (COND),
      .PSR_OUT (PSR_OUT),
      .taken   (cond_taken)
   );

   assign is_rtype = (OP_CODE == REG_ADD'(OPC_RTYPE));
   // Compares update flags only; they have no register write-back.
   assign is_cmp   = (is_rtype && (OP_EXT == REG_ADD'(EXT_CMP))) ||
                     (OP_CODE == REG_ADD'(OPC_CMPI));

   always_comb begin
      state_d      = state_q;
      PC_S         = 1'b0;
      MEM_S        = 1'b0;
      WD_S         = 2'd0;
      ALUA_S       = 2'd0;
      ALUB_S       = 2'd0;
      SE_SIGN      = 1'b0;
      ALU_ADD      = 1'b0;
      instr_en_c   = 1'b0;
      alu_out_en_c = 1'b0;
      mem_reg_en_c = 1'b0;
      pc_en_c      = 1'b0;
      psr_en_c     = 1'b0;
      reg_wr_c     = 1'b0;
      mem_we_c     = 1'b0;

      case (state_q)
         ST_FETCH: begin
            // Read the instruction at PC and compute PC+1 in the same cycle.
            MEM_S   = MEM_S_PC;
            ALUA_S  = ALUA_S_PC;
            ALUB_S  = ALUB_S_ONE;
            ALU_ADD = 1'b1;
            PC_S    = PC_S_ALU;
            if (MEM_READY) begin
               instr_en_c = 1'b1;
               pc_en_c    = 1'b1;
               state_d    = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (is_rtype) begin
               state_d = (OP_EXT == REG_ADD'(EXT_MOV)) ? ST_MOV_WB : ST_EXEC;
            end else if (OP_CODE == REG_ADD'(OPC_MOVI)) begin
               state_d = ST_MOVI_WB;
            end else if (OP_CODE == REG_ADD'(OPC_MEM)) begin
               case (OP_EXT)
                  REG_ADD'(EXT_LOAD):  state_d = ST_LD_RD;
                  REG_ADD'(EXT_STOR):  state_d = ST_ST_WR;
                  REG_ADD'(EXT_JCOND): state_d = ST_JUMP;
                  default:             state_d = ST_FETCH;
               endcase
            end else if (OP_CODE == REG_ADD'(OPC_BCOND)) begin
               state_d = ST_BRANCH;
            end else if (OP_CODE == REG_ADD'(OPC_NOP)) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            alu_out_en_c = 1'b1;
            psr_en_c     = 1'b1;
            if (is_rtype) begin
               ALUA_S = ALUA_S_RSRC;
               ALUB_S = ALUB_S_RDEST;
            end else begin
               ALUA_S  = ALUA_S_IMM;
               ALUB_S  = ALUB_S_IMM;
               SE_SIGN = 1'b1;
            end
            state_d = is_cmp ? ST_FETCH : ST_ALU_WB;
         end

         ST_ALU_WB: begin
            reg_wr_c = 1'b1;
            WD_S     = WD_S_ALU;
            state_d  = ST_FETCH;
         end

         ST_MOV_WB: begin
            reg_wr_c = 1'b1;
            WD_S     = WD_S_RSRC;
            state_d  = ST_FETCH;
         end

         ST_MOVI_WB: begin
            // MOVI loads an unsigned immediate, hence zero extension.
            reg_wr_c = 1'b1;
            WD_S     = WD_S_IMM;
            SE_SIGN  = 1'b0;
            state_d  = ST_FETCH;
         end

         ST_LD_RD: begin
            MEM_S = MEM_S_RDEST;
            if (MEM_READY) begin
               mem_reg_en_c = 1'b1;
               state_d      = ST_LD_WB;
            end
         end

         ST_LD_WB: begin
            reg_wr_c = 1'b1;
            WD_S     = WD_S_MEM;
            state_d  = ST_FETCH;
         end

         ST_ST_WR: begin
            // Write strobe stays up through the completing cycle.
            MEM_S    = MEM_S_RDEST;
            mem_we_c = 1'b1;
            if (MEM_READY) begin
               state_d = ST_FETCH;
            end
         end

         ST_BRANCH: begin
            // PC already holds PC+1 from fetch, so this yields PC+1+disp.
            ALUA_S  = ALUA_S_PC;
            ALUB_S  = ALUB_S_IMM;
            SE_SIGN = 1'b1;
            ALU_ADD = 1'b1;
            PC_S    = PC_S_ALU;
            pc_en_c = cond_taken;
            state_d = ST_FETCH;
         end

         ST_JUMP: begin
            PC_S    = PC_S_RSRC;
            pc_en_c = cond_taken;
            state_d = ST_FETCH;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Count one retired instruction per return to FETCH.
   always_comb begin
      instr_cnt_d = instr_cnt_q;
      if ((state_q != ST_FETCH) && (state_d == ST_FETCH)) begin
         instr_cnt_d = instr_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_FETCH;
         instr_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign INSTR_EN   = instr_en_c   & reset;
   assign ALU_OUT_EN = alu_out_en_c & reset;
   assign MEM_REG_EN = mem_reg_en_c & reset;
   assign PC_EN      = pc_en_c      & reset;
   assign PSR_EN     = psr_en_c     & reset;
   assign REG_WR     = reg_wr_c     & reset;
   assign MEM_WE     = mem_we_c     & reset;

   assign STATE     = state_q;
   assign INSTR_CNT = instr_cnt_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: instruction-level reference model for cpu_controller.
// Each instruction is expanded into its expected per-cycle trace from the
// instruction-class rules (class -> list of phases, plus wait cycles), and
// one compare process checks every driven cycle against that trace.
module tb_cpu_controller;

   localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_ALU_WB = 3;
   localparam int S_MOV_WB = 4, S_MOVI_WB = 5, S_LD_RD = 6, S_LD_WB = 7;
   localparam int S_ST_WR = 8, S_BRANCH = 9, S_JUMP = 10;

   localparam int K_ALU = 0, K_CMP = 1, K_MOV = 2, K_MOVI = 3, K_LD = 4;
   localparam int K_ST = 5, K_JMP = 6, K_BR = 7, K_NOP = 8;

   typedef struct packed {
      logic [3:0]  st;
      logic        pc_s;
      logic        mem_s;
      logic [1:0]  wd_s;
      logic [1:0]  alua_s;
      logic [1:0]  alub_s;
      logic        instr_en;
      logic        alu_out_en;
      logic        mem_reg_en;
      logic        pc_en;
      logic        psr_en;
      logic        reg_wr;
      logic        se_sign;
      logic        mem_we;
      logic        alu_add;
      logic [15:0] cnt;
   } cyc_t;

   logic clk;
   logic rst_n;

   cpu_controller_if #(.REG_ADD(4), .PSRL(5)) bus ();

   cpu_controller #(.REG_ADD(4), .PSRL(5)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .OP_CODE    (bus.OP_CODE),
      .OP_EXT     (bus.OP_EXT),
      .COND       (bus.COND),
      .PSR_OUT    (bus.PSR_OUT),
      .MEM_READY  (bus.MEM_READY),
      .PC_S       (bus.PC_S),
      .MEM_S      (bus.MEM_S),
      .WD_S       (bus.WD_S),
      .ALUA_S     (bus.ALUA_S),
      .ALUB_S     (bus.ALUB_S),
      .INSTR_EN   (bus.INSTR_EN),
      .ALU_OUT_EN (bus.ALU_OUT_EN),
      .MEM_REG_EN (bus.MEM_REG_EN),
      .PC_EN      (bus.PC_EN),
      .PSR_EN     (bus.PSR_EN),
      .REG_WR     (bus.REG_WR),
      .SE_SIGN    (bus.SE_SIGN),
      .MEM_WE     (bus.MEM_WE),
      .ALU_ADD    (bus.ALU_ADD),
      .STATE      (bus.STATE),
      .INSTR_CNT  (bus.INSTR_CNT)
   );

   logic [36:0] exp_q[$];
   logic [36:0] obs_q[$];
   logic [15:0] model_cnt;
   int          checks_done;
   int          checks_passed;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int classify(logic [3:0] op, logic [3:0] ext);
      if (op == 4'b0000) begin
         if (ext == 4'b1101) return K_MOV;
         if (ext == 4'b1011) return K_CMP;
         return K_ALU;
      end
      if (op == 4'b1101) return K_MOVI;
      if (op == 4'b0100) begin
         if (ext == 4'b0000) return K_LD;
         if (ext == 4'b0100) return K_ST;
         if (ext == 4'b1100) return K_JMP;
         return K_NOP;
      end
      if (op == 4'b1100) return K_BR;
      if (op == 4'b1111) return K_NOP;
      if (op == 4'b1011) return K_CMP;
      return K_ALU;
   endfunction

   function automatic bit model_taken(logic [3:0] cond, logic [4:0] psr);
      bit n, z, c;
      n = psr[4];
      z = psr[3];
      c = psr[0];
      case (cond)
         4'b0000: return z;
         4'b0001: return !z;
         4'b0010: return c;
         4'b0011: return !c;
         4'b0110: return n;
         4'b0111: return !n;
         4'b1110: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Outputs a phase must show; everything not named stays 0.
   function automatic cyc_t model_cycle(int st, bit mr, bit imm, bit tk,
                                        logic [15:0] cnt);
      cyc_t c;
      c     = '0;
      c.st  = 4'(st);
      c.cnt = cnt;
      case (st)
         S_FETCH: begin
            c.mem_s = 1'b1; c.alua_s = 2'd1; c.alub_s = 2'd2;
            c.alu_add = 1'b1; c.pc_s = 1'b1;
            c.instr_en = mr; c.pc_en = mr;
         end
         S_EXEC: begin
            c.alu_out_en = 1'b1; c.psr_en = 1'b1;
            if (imm) begin
               c.alua_s = 2'd2; c.alub_s = 2'd1; c.se_sign = 1'b1;
            end
         end
         S_ALU_WB:  begin c.reg_wr = 1'b1; c.wd_s = 2'd3; end
         S_MOV_WB:  begin c.reg_wr = 1'b1; c.wd_s = 2'd1; end
         S_MOVI_WB: begin c.reg_wr = 1'b1; c.wd_s = 2'd0; end
         S_LD_RD:   c.mem_reg_en = mr;
         S_LD_WB:   begin c.reg_wr = 1'b1; c.wd_s = 2'd2; end
         S_ST_WR:   c.mem_we = 1'b1;
         S_BRANCH: begin
            c.alua_s = 2'd1; c.alub_s = 2'd1; c.se_sign = 1'b1;
            c.alu_add = 1'b1; c.pc_s = 1'b1; c.pc_en = tk;
         end
         S_JUMP:    c.pc_en = tk;
         default:   ;
      endcase
      return c;
   endfunction

   function automatic cyc_t sample_dut();
      cyc_t c;
      c.st         = bus.STATE;
      c.pc_s       = bus.PC_S;
      c.mem_s      = bus.MEM_S;
      c.wd_s       = bus.WD_S;
      c.alua_s     = bus.ALUA_S;
      c.alub_s     = bus.ALUB_S;
      c.instr_en   = bus.INSTR_EN;
      c.alu_out_en = bus.ALU_OUT_EN;
      c.mem_reg_en = bus.MEM_REG_EN;
      c.pc_en      = bus.PC_EN;
      c.psr_en     = bus.PSR_EN;
      c.reg_wr     = bus.REG_WR;
      c.se_sign    = bus.SE_SIGN;
      c.mem_we     = bus.MEM_WE;
      c.alu_add    = bus.ALU_ADD;
      c.cnt        = bus.INSTR_CNT;
      return c;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [36:0] act,
                        input logic [36:0] exp);
      checks_done++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin : compare_proc
      cyc_t e, a;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = sample_dut();
         obs_q.push_back(a);
         check($sformatf("cycle_state%0d", e.st), a, e);
      end
   end

   // ---------------- driver tasks ----------------
   // Runs one instruction: fw fetch wait cycles, mw memory wait cycles.
   task automatic run_instr(input logic [3:0] op, input logic [3:0] ext,
                            input logic [3:0] cond, input logic [4:0] psr,
                            input int fw, input int mw, output int ncyc);
      int st_l[$];
      bit mr_l[$];
      int k;
      bit imm, tk;
      cyc_t e;
      k   = classify(op, ext);
      imm = (op != 4'b0000);
      tk  = model_taken(cond, psr);
      for (int i = 0; i < fw; i++) begin st_l.push_back(S_FETCH); mr_l.push_back(1'b0); end
      st_l.push_back(S_FETCH);  mr_l.push_back(1'b1);
      st_l.push_back(S_DECODE); mr_l.push_back(1'($urandom_range(0, 1)));
      case (k)
         K_ALU: begin
            st_l.push_back(S_EXEC);   mr_l.push_back(1'($urandom_range(0, 1)));
            st_l.push_back(S_ALU_WB); mr_l.push_back(1'($urandom_range(0, 1)));
         end
         K_CMP:  begin st_l.push_back(S_EXEC);    mr_l.push_back(1'($urandom_range(0, 1))); end
         K_MOV:  begin st_l.push_back(S_MOV_WB);  mr_l.push_back(1'($urandom_range(0, 1))); end
         K_MOVI: begin st_l.push_back(S_MOVI_WB); mr_l.push_back(1'($urandom_range(0, 1))); end
         K_LD: begin
            for (int i = 0; i < mw; i++) begin st_l.push_back(S_LD_RD); mr_l.push_back(1'b0); end
            st_l.push_back(S_LD_RD); mr_l.push_back(1'b1);
            st_l.push_back(S_LD_WB); mr_l.push_back(1'($urandom_range(0, 1)));
         end
         K_ST: begin
            for (int i = 0; i < mw; i++) begin st_l.push_back(S_ST_WR); mr_l.push_back(1'b0); end
            st_l.push_back(S_ST_WR); mr_l.push_back(1'b1);
         end
         K_JMP: begin st_l.push_back(S_JUMP);   mr_l.push_back(1'($urandom_range(0, 1))); end
         K_BR:  begin st_l.push_back(S_BRANCH); mr_l.push_back(1'($urandom_range(0, 1))); end
         default: ;
      endcase
      ncyc = st_l.size();
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         bus.OP_CODE   = op;
         bus.OP_EXT    = ext;
         bus.COND      = cond;
         bus.PSR_OUT   = psr;
         bus.MEM_READY = mr_l[i];
         e = model_cycle(st_l[i], mr_l[i], imm, tk, model_cnt);
         exp_q.push_back(e);
      end
      model_cnt = model_cnt + 16'd1;
      #3;
   endtask

   // One unchecked cycle with memory not ready, so the DUT parks in FETCH.
   task automatic idle();
      @(negedge clk);
      bus.MEM_READY = 1'b0;
      #2;
   endtask

   // ---------------- stimulus ----------------
   logic [3:0] sp_op[6]  = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b1100, 4'b1101};
   logic [3:0] sp_ext[5] = '{4'b0000, 4'b0100, 4'b1100, 4'b1101, 4'b1011};

   initial begin : main
      int n, cnt_we;
      cyc_t o, o2;
      logic [3:0] op, ext;
      checks_done   = 0;
      checks_passed = 0;
      model_cnt     = 16'd0;
      bus.OP_CODE   = 4'd0;
      bus.OP_EXT    = 4'd0;
      bus.COND      = 4'd0;
      bus.PSR_OUT   = 5'd0;
      bus.MEM_READY = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset: FETCH, count 0, enables forced low despite MEM_READY=1
      repeat (3) @(negedge clk);
      #2;
      check("reset_state", bus.STATE, 0);
      check("reset_cnt", bus.INSTR_CNT, 0);
      check("reset_instr_en", bus.INSTR_EN, 0);
      check("reset_pc_en", bus.PC_EN, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.MEM_READY = 1'b0;

      // ALU register op: states 0,1,2,3 then FETCH, count 1
      obs_q.delete();
      run_instr(4'b0000, 4'b0101, 4'd0, 5'd0, 0, 0, n);
      check("alu_latency", n, 4);
      for (int i = 0; i < 4; i++) begin
         o = obs_q[i];
         check($sformatf("alu_state_%0d", i), o.st, i);
         check($sformatf("alu_regwr_%0d", i), o.reg_wr, (i == 3) ? 1 : 0);
      end
      idle();
      check("alu_back_to_fetch", bus.STATE, 0);
      check("alu_instr_cnt", bus.INSTR_CNT, 1);

      // Fetch with 3 wait cycles
      obs_q.delete();
      run_instr(4'b1111, 4'd0, 4'd0, 5'd0, 3, 0, n);
      check("nop_wait_latency", n, 5);
      for (int i = 0; i < 4; i++) begin
         o = obs_q[i];
         check($sformatf("fetch_wait_instr_en_%0d", i), o.instr_en, (i == 3) ? 1 : 0);
      end

      // Branch EQ taken / not taken
      obs_q.delete();
      run_instr(4'b1100, 4'd0, 4'b0000, 5'b01000, 0, 0, n);
      o = obs_q[2];
      check("br_latency", n, 3);
      check("br_taken_state", o.st, 9);
      check("br_taken_pc_en", o.pc_en, 1);
      obs_q.delete();
      run_instr(4'b1100, 4'd0, 4'b0000, 5'b00000, 0, 0, n);
      o = obs_q[2];
      check("br_not_taken_pc_en", o.pc_en, 0);
      idle();
      check("br_back_to_fetch", bus.STATE, 0);

      // Load
      obs_q.delete();
      run_instr(4'b0100, 4'b0000, 4'd0, 5'd0, 0, 0, n);
      o  = obs_q[2];
      o2 = obs_q[3];
      check("ld_latency", n, 4);
      check("ld_rd_state", o.st, 6);
      check("ld_rd_mem_reg_en", o.mem_reg_en, 1);
      check("ld_wb_state", o2.st, 7);
      check("ld_wb_reg_wr", o2.reg_wr, 1);
      check("ld_wb_wd_s", o2.wd_s, 2);

      // Store with 2 memory wait cycles
      obs_q.delete();
      run_instr(4'b0100, 4'b0100, 4'd0, 5'd0, 0, 2, n);
      cnt_we = 0;
      foreach (obs_q[i]) begin
         o = obs_q[i];
         if (o.mem_we) cnt_we++;
      end
      check("st_wait_latency", n, 5);
      check("st_mem_we_cycles", cnt_we, 3);

      // Reset during the second ST_WR cycle
      @(negedge clk);
      bus.OP_CODE = 4'b0100; bus.OP_EXT = 4'b0100; bus.MEM_READY = 1'b1;
      @(negedge clk);
      bus.MEM_READY = 1'b0;
      @(negedge clk);
      #2;
      check("st_mid_mem_we_before", bus.MEM_WE, 1);
      check("st_mid_state_before", bus.STATE, 8);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("st_mid_reset_mem_we", bus.MEM_WE, 0);
      check("st_mid_reset_state", bus.STATE, 0);
      check("st_mid_reset_cnt", bus.INSTR_CNT, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_cnt = 16'd0;

      // Randomized instruction stream
      for (int t = 0; t < 250; t++) begin
         op  = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : sp_op[$urandom_range(0, 5)];
         ext = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : sp_ext[$urandom_range(0, 4)];
         run_instr(op, ext, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                   $urandom_range(0, 2), $urandom_range(0, 2), n);
      end

      // Counter wrap: preload 0xFFFF while parked in FETCH, retire a NOP
      idle();
      force dut.instr_cnt_d = 16'hFFFF;
      @(posedge clk);
      #1 release dut.instr_cnt_d;
      model_cnt = 16'hFFFF;
      idle();
      check("cnt_preload", bus.INSTR_CNT, 16'hFFFF);
      run_instr(4'b1111, 4'd0, 4'd0, 5'd0, 0, 0, n);
      idle();
      check("cnt_wrap", bus.INSTR_CNT, 0);

      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) check("exp_q_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_done);
      $finish;
   end

endmodule
